// File: rtl/stm_update_scheduler_pkg.sv
// stm_update_scheduler shared types and constants.
// Scheduler state encoding, period/depth defaults, helpers.
package stm_update_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ISSUE,
    COLLECT
  } sched_state_t;

  localparam int STM_UPDATE_PERIOD_BITS = 9;
  localparam int STM_UPDATE_DEPTH = 249;
  localparam int SYS_TIME_W = 56;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/stm_update_scheduler_tick.sv
// sys_time_tick: period boundary detector on SYS_TIME phase.
// Ports: CLK, PHASE (low SYS_TIME bits), TICK (phase wrapped).
module sys_time_tick #(
  parameter int PERIOD_BITS = 9
) (
  input  logic                   CLK,
  input  logic [PERIOD_BITS-1:0] PHASE,
  output logic                   TICK
);

  logic [PERIOD_BITS-1:0] prev_phase;

  // Loaded every cycle, reset included, so the cycle
  // after reset never sees a spurious wrap.
  always_ff @(posedge CLK) begin
    prev_phase <= PHASE;
  end

  // A drop in phase means a boundary was crossed, even
  // when SYS_TIME jumps by more than one.
  assign TICK = PHASE < prev_phase;

endmodule

// File: rtl/stm_update_scheduler.sv
// stm_update_scheduler: paces stm UPDATEs, counts beats, flags overruns.
// Ports: CLK, RST (sync, high), SYS_TIME, ENABLE, DOUT_VALID,
//   OVERRUN_CLR in; UPDATE, BUSY, DONE, FRAME_CNT, OVERRUN,
//   OVERRUN_CNT, STRAY out (all registered).
module stm_update_scheduler
  import stm_update_scheduler_pkg::*;
#(
  parameter int DEPTH       = STM_UPDATE_DEPTH,
  parameter int PERIOD_BITS = STM_UPDATE_PERIOD_BITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [SYS_TIME_W-1:0] SYS_TIME,
  input  logic                  ENABLE,
  input  logic                  DOUT_VALID,
  input  logic                  OVERRUN_CLR,
  output logic                  UPDATE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           FRAME_CNT,
  output logic                  OVERRUN,
  output logic [7:0]            OVERRUN_CNT,
  output logic                  STRAY
);

  localparam int BW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] LAST = BW'(DEPTH - 1);

  sched_state_t  state;
  logic [BW-1:0] beat_cnt;

  logic tick;
  logic collecting;
  logic last_beat;
  logic go_issue;
  logic overrun_hit;
  logic unused_hi;

  // Only the phase bits matter for boundary detection.
  assign unused_hi = ^SYS_TIME[SYS_TIME_W-1:PERIOD_BITS];

  sys_time_tick #(
    .PERIOD_BITS(PERIOD_BITS)
  ) u_tick (
    .CLK  (CLK),
    .PHASE(SYS_TIME[PERIOD_BITS-1:0]),
    .TICK (tick)
  );

  assign collecting = state == COLLECT;
  assign last_beat  = collecting && DOUT_VALID &&
                      beat_cnt == LAST;

  // A boundary starts a new burst from ARMED, and also
  // from COLLECT: either the burst just finished on this
  // very beat, or it is abandoned as an overrun.
  assign go_issue    = ENABLE && tick &&
                       (state == ARMED || collecting);
  assign overrun_hit = go_issue && collecting &&
                       !last_beat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      UPDATE      <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      FRAME_CNT   <= '0;
      OVERRUN     <= 1'b0;
      OVERRUN_CNT <= '0;
      STRAY       <= 1'b0;
    end else begin
      UPDATE <= 1'b0;
      DONE   <= last_beat;

      if (DOUT_VALID && !collecting) begin
        STRAY <= 1'b1;
      end

      // A fresh overrun beats a simultaneous clear.
      if (overrun_hit) begin
        OVERRUN     <= 1'b1;
        OVERRUN_CNT <= OVERRUN_CLR ? 8'd1 :
                       sat_inc8(OVERRUN_CNT);
      end else if (OVERRUN_CLR) begin
        OVERRUN     <= 1'b0;
        OVERRUN_CNT <= '0;
      end

      if (go_issue) begin
        state     <= ISSUE;
        UPDATE    <= 1'b1;
        BUSY      <= 1'b1;
        FRAME_CNT <= FRAME_CNT + 16'd1;
      end else begin
        unique case (state)
          IDLE, ARMED: begin
            state <= ENABLE ? ARMED : IDLE;
          end
          ISSUE: begin
            state    <= COLLECT;
            beat_cnt <= '0;
          end
          COLLECT: begin
            if (DOUT_VALID) begin
              beat_cnt <= beat_cnt + BW'(1);
            end
            // Completion ignores ENABLE; only the
            // follow-on state depends on it.
            if (last_beat) begin
              state <= ENABLE ? ARMED : IDLE;
              BUSY  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
